sram_byte_en_rmw_adapter: RTL

Read-modify-write engine between a byte-enable SRAM client (the AXI4 byte-enable SRAM bridge) and a line-enable SRAM macro that has no byte write strobes. Partial-line writes become a line read, a per-byte merge and a full-line write-back. Reads pass through with a registered response. One request is in flight at a time, under a valid/ready handshake.

---
 rtl/sram_byte_en_rmw_adapter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_byte_en_rmw_adapter.sv
// sram_byte_en_rmw_adapter
// ------------------------
// Read-modify-write engine that sits between a byte-enable SRAM client and
// a line-enable SRAM macro. The macro has no byte write strobes. A partial
// write therefore becomes three steps: a line read, a per-byte merge, and a
// full-line write-back. Reads pass through with a registered response.
// Only one request is in flight at a time.
//
// Optional feature (compile-time macro):
//   SRAM_RMW_FULL_LINE_BYPASS_EN - a write whose byte strobes are all ones
//   skips the SRAM read and goes straight from IDLE to WR.
//
// Ports:
//   clk, rst          - single clock; rst is asynchronous and active-high
//   req_valid/ready   - request handshake (see below)
//   req_write         - 1 = write, 0 = read
//   req_addr          - line address
//   req_wdata         - write data
//   req_byte_en       - byte strobes; bit i covers bits [8i+7:8i]; unused for reads
//   rsp_valid         - one-cycle completion pulse (no backpressure)
//   rsp_write         - the completed operation was a write
//   rsp_rdata         - read data, or the line as written for writes
//   sram_addr         - SRAM line address (holds its last value when idle)
//   sram_read_en      - SRAM read strobe; data returns on the following cycle
//   sram_write_en     - SRAM full-line write strobe
//   sram_write_data   - SRAM full-line write data
//   sram_read_data    - SRAM read data, valid the cycle after sram_read_en
//   dbg_state         - current FSM state, for observation only
//
// Handshake: a request transfers on any rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE. Request inputs are
// don't-care on every other cycle. rsp_valid is a single-cycle pulse that
// the client must take; it cannot stall it.
module sram_byte_en_rmw_adapter #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int DATA_WIDTH    = 64,
  localparam int NBYTES       = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [MEM_ADDR_BITS-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [NBYTES-1:0]        req_byte_en,
  output logic                     rsp_valid,
  output logic                     rsp_write,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [MEM_ADDR_BITS-1:0] sram_addr,
  output logic                     sram_read_en,
  output logic                     sram_write_en,
  output logic [DATA_WIDTH-1:0]    sram_write_data,
  input  logic [DATA_WIDTH-1:0]    sram_read_data,
  output logic [2:0]               dbg_state
);

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("sram_byte_en_rmw_adapter: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [NBYTES-1:0]        byte_en_q, byte_en_d;
  logic                     write_q, write_d;
  logic [DATA_WIDTH-1:0]    line_q, line_d;

  // Every output is a flop. Its next value is computed from the state
  // transition, so each strobe lines up exactly with the state it belongs to.
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [MEM_ADDR_BITS-1:0] sram_addr_q, sram_addr_d;
  logic                     sram_read_en_q, sram_read_en_d;
  logic                     sram_write_en_q, sram_write_en_d;
  logic [DATA_WIDTH-1:0]    sram_write_data_q, sram_write_data_d;

  logic [DATA_WIDTH-1:0]    merged;

  // Per-byte merge of the registered write data over the line being read back.
  always_comb begin
    merged = '0;
    for (int i = 0; i < NBYTES; i++) begin
      merged[8*i +: 8] = byte_en_q[i] ? wdata_q[8*i +: 8] : sram_read_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    byte_en_d         = byte_en_q;
    write_d           = write_q;
    line_d            = line_q;
    rsp_valid_d       = 1'b0;
    rsp_write_d       = rsp_write_q;
    rsp_rdata_d       = rsp_rdata_q;
    sram_addr_d       = sram_addr_q;
    sram_read_en_d    = 1'b0;
    sram_write_en_d   = 1'b0;
    sram_write_data_d = sram_write_data_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          byte_en_d = req_byte_en;
          write_d   = req_write;
          if (req_write && (req_byte_en == '0)) begin
            // Nothing to write: complete without touching the SRAM.
            state_d     = RSP;
            line_d      = '0;
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_rdata_d = '0;
          end
`ifdef SRAM_RMW_FULL_LINE_BYPASS_EN
          else if (req_write && (&req_byte_en)) begin
            // The whole line is replaced, so the read-back is not needed.
            state_d           = WR;
            line_d            = req_wdata;
            sram_addr_d       = req_addr;
            sram_write_en_d   = 1'b1;
            sram_write_data_d = req_wdata;
          end
`endif
          else begin
            state_d        = RD;
            sram_addr_d    = req_addr;
            sram_read_en_d = 1'b1;
          end
        end
      end
      RD: begin
        state_d = RDW;
      end
      RDW: begin
        if (write_q) begin
          state_d           = WR;
          line_d            = merged;
          sram_addr_d       = addr_q;
          sram_write_en_d   = 1'b1;
          sram_write_data_d = merged;
        end else begin
          state_d     = RSP;
          line_d      = sram_read_data;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = sram_read_data;
        end
      end
      WR: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_write_d = write_q;
        rsp_rdata_d = line_q;
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      wdata_q           <= '0;
      byte_en_q         <= '0;
      write_q           <= 1'b0;
      line_q            <= '0;
      rsp_valid_q       <= 1'b0;
      rsp_write_q       <= 1'b0;
      rsp_rdata_q       <= '0;
      sram_addr_q       <= '0;
      sram_read_en_q    <= 1'b0;
      sram_write_en_q   <= 1'b0;
      sram_write_data_q <= '0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      byte_en_q         <= byte_en_d;
      write_q           <= write_d;
      line_q            <= line_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_write_q       <= rsp_write_d;
      rsp_rdata_q       <= rsp_rdata_d;
      sram_addr_q       <= sram_addr_d;
      sram_read_en_q    <= sram_read_en_d;
      sram_write_en_q   <= sram_write_en_d;
      sram_write_data_q <= sram_write_data_d;
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_write       = rsp_write_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign sram_addr       = sram_addr_q;
  assign sram_read_en    = sram_read_en_q;
  assign sram_write_en   = sram_write_en_q;
  assign sram_write_data = sram_write_data_q;
  assign dbg_state       = state_q;

endmodule
